// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB high-speed receive front end
// (NRZI decode, SYNC hunt, bit unstuffing, deserializer).
package usb_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        DATA    = 2'd1,
        WAIT_SQ = 2'd2
    } rx_state_e;

    localparam int SYNC_MIN_ZEROS_DEF = 12;
    localparam int STUFF_LIMIT_DEF    = 6;
    localparam int ONES_CNT_W         = $clog2(STUFF_LIMIT_DEF + 1);

    // Bits needed for a counter that must be able to hold maxv.
    function automatic int cnt_w(input int maxv);
        return $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/usb_rx_nrzi_unstuff_if.sv
// Line-side inputs and UTMI-style byte-stream outputs of the receive stage.
interface usb_rx_nrzi_unstuff_if;
    logic       data_in;
    logic       squelch;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;

    modport master (
        output data_in, squelch,
        input  rx_data, rx_valid, rx_active, rx_error
    );

    modport slave (
        input  data_in, squelch,
        output rx_data, rx_valid, rx_active, rx_error
    );
endinterface

// File: rtl/usb_rx_nrzi_unstuff_decoder.sv
// NRZI decoder: a line level equal to the previous one decodes as 1.
module usb_nrzi_decoder (
    input  logic clock_480,
    input  logic reset,
    input  logic line_i,
    output logic dec_o
);
    logic prev_level_q;

    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset) begin
            prev_level_q <= 1'b0;
        end else begin
            prev_level_q <= line_i;
        end
    end

    assign dec_o = ~(line_i ^ prev_level_q);
endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// HS receive stage: hunts for SYNC, strips stuffed bits, assembles bytes
// LSB-first and flags EOP / squelch terminations on a UTMI-style stream.
module usb_rx_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
    parameter int STUFF_LIMIT    = STUFF_LIMIT_DEF
) (
    input  logic                 clock_480,
    input  logic                 reset,
    usb_rx_nrzi_unstuff_if.slave rx_if
);
    localparam int ZERO_W = cnt_w(SYNC_MIN_ZEROS);
    localparam int ONES_W = cnt_w(STUFF_LIMIT);
    localparam logic [ZERO_W-1:0] ZERO_SAT = ZERO_W'(SYNC_MIN_ZEROS);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);

    logic dec;

    rx_state_e         state_q, state_d;
    logic [ZERO_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_active_q, rx_active_d;
    logic              rx_error_q, rx_error_d;

    usb_nrzi_decoder u_dec (
        .clock_480 (clock_480),
        .reset     (reset),
        .line_i    (rx_if.data_in),
        .dec_o     (dec)
    );

    always_comb begin
        state_d     = state_q;
        zero_cnt_d  = zero_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_active_d = rx_active_q;
        rx_valid_d  = 1'b0;
        rx_error_d  = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (rx_if.squelch) begin
                    zero_cnt_d = '0;
                end else if (!dec) begin
                    if (zero_cnt_q != ZERO_SAT) begin
                        zero_cnt_d = zero_cnt_q + 1'b1;
                    end
                end else begin
                    zero_cnt_d = '0;
                    if (zero_cnt_q >= ZERO_SAT) begin
                        state_d     = DATA;
                        rx_active_d = 1'b1;
                        ones_cnt_d  = '0;
                        bit_cnt_d   = '0;
                        shreg_d     = '0;
                    end
                end
            end

            DATA: begin
                // Squelch outranks a stuff violation, which outranks byte completion.
                if (rx_if.squelch) begin
                    state_d     = HUNT;
                    zero_cnt_d  = '0;
                    rx_active_d = 1'b0;
                    rx_error_d  = (bit_cnt_q != 3'd0);
                end else if (ones_cnt_q == ONES_MAX) begin
                    if (!dec) begin
                        ones_cnt_d = '0;
                    end else begin
                        // Seven 1s ending exactly one bit short of a byte is the HS EOP.
                        state_d     = WAIT_SQ;
                        rx_active_d = 1'b0;
                        rx_error_d  = (bit_cnt_q != 3'd7);
                    end
                end else begin
                    shreg_d    = {dec, shreg_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    ones_cnt_d = dec ? ones_cnt_q + 1'b1 : '0;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {dec, shreg_q[7:1]};
                        rx_valid_d = 1'b1;
                    end
                end
            end

            WAIT_SQ: begin
                if (rx_if.squelch) begin
                    state_d    = HUNT;
                    zero_cnt_d = '0;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            zero_cnt_q  <= '0;
            ones_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_cnt_q  <= zero_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.rx_active = rx_active_q;
    assign rx_if.rx_error  = rx_error_q;
endmodule
